// File: rtl/iter_mult64_if.sv
// Request/response bundle for iter_mult64: requester drives start and operands,
// the multiplier returns product, overflow, done and busy.
interface iter_mult64_if;
   logic        start;
   logic [63:0] mcand;
   logic [63:0] mplier;
   logic [63:0] product;
   logic        overflow;
   logic        done;
   logic        busy;

   modport master (
      output start, mcand, mplier,
      input  product, overflow, done, busy
   );

   modport slave (
      input  start, mcand, mplier,
      output product, overflow, done, busy
   );
endinterface

// File: rtl/iter_mult64.sv
// Iterative unsigned 64x64 multiplier, BITS_PER_STEP multiplier bits per clock.
// Define ITER_MULT_EARLY_TERM_EN to finish once the remaining multiplier bits are zero.
module iter_mult64 #(
   parameter int unsigned BITS_PER_STEP = 8
) (
   input logic          clock,
   input logic          reset,
   iter_mult64_if.slave bus
);
   localparam int unsigned STEPS = 64 / BITS_PER_STEP;
   localparam int unsigned KW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [6:0]  B7    = 7'(BITS_PER_STEP);

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   state_e                   state_q, state_d;
   logic [63:0]              mcand_q, mcand_d;
   logic [63:0]              mplier_q, mplier_d;
   logic [127:0]             acc_q, acc_d;
   logic [KW-1:0]            k_q, k_d;
   logic [63:0]              product_q, product_d;
   logic                     overflow_q, overflow_d;
   logic                     done_q, done_d;
   logic                     busy_q, busy_d;

   logic [6:0]               shift;
   logic [63:0]              hi;
   logic [BITS_PER_STEP-1:0] chunk;
   logic [63+BITS_PER_STEP:0] pp;
   logic [127:0]             term;
   logic [127:0]             acc_next;
   logic                     last;

   // Partial product for chunk k, aligned to its weight in the 128-bit result.
   always_comb begin
      shift    = 7'(k_q) * B7;
      hi       = mplier_q >> shift;
      chunk    = hi[BITS_PER_STEP-1:0];
      pp       = {{BITS_PER_STEP{1'b0}}, mcand_q} * {64'd0, chunk};
      term     = 128'(pp) << shift;
      acc_next = acc_q + term;
`ifdef ITER_MULT_EARLY_TERM_EN
      last     = (k_q == KW'(STEPS - 1)) || ((hi >> BITS_PER_STEP) == 64'd0);
`else
      last     = (k_q == KW'(STEPS - 1));
`endif
   end

   always_comb begin
      state_d    = state_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      k_d        = k_q;
      product_d  = product_q;
      overflow_d = overflow_q;
      done_d     = done_q;
      busy_d     = busy_q;
      unique case (state_q)
         StIdle, StFin: begin
            if (bus.start) begin
               mcand_d  = bus.mcand;
               mplier_d = bus.mplier;
               acc_d    = '0;
               k_d      = '0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               state_d  = StRun;
            end
         end
         StRun: begin
            acc_d = acc_next;
            if (last) begin
               product_d  = acc_next[63:0];
               overflow_d = |acc_next[127:64];
               done_d     = 1'b1;
               busy_d     = 1'b0;
               state_d    = StFin;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         k_q        <= '0;
         product_q  <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         k_q        <= k_d;
         product_q  <= product_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.product  = product_q;
   assign bus.overflow = overflow_q;
   assign bus.done     = done_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_iter_mult64.sv
// Self-checking bench for iter_mult64 against a plain-arithmetic reference model.
module tb_iter_mult64;
   localparam int B     = 8;
   localparam int STEPS = 64 / B;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   chk_cnt  = 0;
   int   pass_cnt = 0;

   iter_mult64_if bus ();

   iter_mult64 #(.BITS_PER_STEP(B)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [127:0] full_prod(input logic [63:0] a, input logic [63:0] b);
      return {64'd0, a} * {64'd0, b};
   endfunction

   function automatic int exp_lat(input logic [63:0] b);
      int lat;
`ifdef ITER_MULT_EARLY_TERM_EN
      lat = 1;
      for (int i = 0; i < STEPS; i++)
         if (((b >> (i * B)) & ((64'd1 << B) - 64'd1)) != 64'd0) lat = i + 1;
`else
      lat = STEPS;
`endif
      return lat;
   endfunction

   // Issue one request and check latency, product and overflow.
   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input string name);
      logic [127:0] ref_full;
      int           cnt;
      ref_full   = full_prod(a, b);
      bus.start  = 1'b1;
      bus.mcand  = a;
      bus.mplier = b;
      tick();
      bus.start  = 1'b0;
      chk_cnt++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0)
         $display("FAIL %s accept: busy=%b done=%b, need busy=1 done=0", name, bus.busy, bus.done);
      else pass_cnt++;
      cnt = 0;
      while (bus.done !== 1'b1 && cnt < 100) begin
         tick();
         cnt++;
      end
      chk_cnt++;
      if (cnt != exp_lat(b)) $display("FAIL %s latency: got %0d need %0d", name, cnt, exp_lat(b));
      else pass_cnt++;
      chk_cnt++;
      if (bus.product !== ref_full[63:0] || bus.overflow !== (|ref_full[127:64]) || bus.busy !== 1'b0)
         $display("FAIL %s result: product=%h ovf=%b busy=%b, need product=%h ovf=%b busy=0",
                  name, bus.product, bus.overflow, bus.busy, ref_full[63:0], |ref_full[127:64]);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_cnt++;
         if (bus.product !== 64'd0 || bus.overflow !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL reset_idle%0d: product=%h ovf=%b done=%b busy=%b, need all 0",
                     i, bus.product, bus.overflow, bus.done, bus.busy);
         else pass_cnt++;
      end
   endtask

   task automatic test_directed();
      run_op(64'hFFFF_FFFF, 64'hFFFF_FFFF, "sq32");
      run_op(64'd3, 64'd5, "3x5");
      run_op(64'd3, 64'd0, "3x0");
      run_op(64'h1_0000_0000, 64'h1_0000_0000, "ovf_2p64");
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, "max_x2");
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "max_sq");
   endtask

   task automatic test_random();
      logic [63:0] a, b;
      for (int i = 0; i < 20; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         // Narrow some multipliers so early termination sees varied chunk counts.
         if (i % 2 == 1) b = b >> ($urandom_range(63, 1));
         run_op(a, b, $sformatf("rand%0d", i));
      end
   endtask

   task automatic test_back_to_back();
      int cnt;
      bus.start  = 1'b1;
      bus.mcand  = 64'd7;
      bus.mplier = 64'd6;
      tick();
      bus.start  = 1'b0;
      tick();
      tick();
      // Mid-run request must be ignored.
      if (bus.busy === 1'b1) begin
         bus.start  = 1'b1;
         bus.mcand  = 64'd9;
         bus.mplier = 64'd9;
         tick();
         bus.start  = 1'b0;
         chk_cnt++;
         if (bus.busy !== 1'b1) $display("FAIL ignore_start busy: got %b need 1", bus.busy);
         else pass_cnt++;
      end
      cnt = 0;
      while (bus.done !== 1'b1 && cnt < 100) begin
         tick();
         cnt++;
      end
      chk_cnt++;
      if (bus.done !== 1'b1 || bus.product !== 64'd42)
         $display("FAIL ignore_start result: done=%b product=%0d need done=1 product=42",
                  bus.done, bus.product);
      else pass_cnt++;
      run_op(64'd9, 64'd9, "b2b_9x9");
   endtask

   task automatic test_reset_mid();
      int seen;
      bus.start  = 1'b1;
      bus.mcand  = 64'hFFFF_FFFF;
      bus.mplier = 64'hFFFF_FFFF;
      tick();
      bus.start  = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk_cnt++;
      if (bus.product !== 64'd0 || bus.overflow !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL reset_mid: product=%h ovf=%b done=%b busy=%b, need all 0",
                  bus.product, bus.overflow, bus.done, bus.busy);
      else pass_cnt++;
      // Reset wins over a simultaneous start.
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      reset     = 1'b0;
      chk_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL reset_prio busy: got %b need 0", bus.busy);
      else pass_cnt++;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      end
      chk_cnt++;
      if (seen != 0) $display("FAIL reset_abort: done/busy seen %0d cycles need 0", seen);
      else pass_cnt++;
      run_op(64'd2, 64'd2, "after_reset_2x2");
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.mcand  = 64'd0;
      bus.mplier = 64'd0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
